// File: rtl/csl_arbiter.sv
// Round-robin arbiter sharing one 16-bit circular-shift-left unit among NREQ requesters.
// Define CSL_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module csl_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_din,
  input  logic [4*NREQ-1:0]    req_amt,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          csl_din,
  output logic [15:0]          csl_amount,
  input  logic [15:0]          csl_dout,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_dout,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    win_id_q, win_id_d;
  logic [DW-1:0]     csl_din_q, csl_din_d;
  logic [DW-1:0]     csl_amount_q, csl_amount_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [DW-1:0]     rsp_dout_q, rsp_dout_d;
  logic              busy_q, busy_d;

  logic [IDW-1:0]    scan_base_c;
  logic              any_req_c;
  logic [IDW-1:0]    win_c;
  logic [DW-1:0]     win_din_c;
  logic [AW-1:0]     win_amt_c;
  logic              handshake_c;
  int unsigned       scan_pos;
  logic [IDW-1:0]    scan_idx;

  logic [DW-1:0]     din_a [NREQ];
  logic [AW-1:0]     amt_a [NREQ];

  // Unpack the flat operand buses into per-requester views.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign din_a[g] = req_din[DW*g +: DW];
    assign amt_a[g] = req_amt[AW*g +: AW];
  end

  assign handshake_c = (state_q == S_RESP) && rsp_ready;

`ifdef CSL_ARB_FIXED_PRIO_EN
  assign scan_base_c = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer moves to the slot after the last winner once its response is taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (handshake_c) begin
      rr_ptr_d = (win_id_q == IDW'(NREQ - 1)) ? '0 : win_id_q + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign scan_base_c = rr_ptr_q;
`endif

  // First asserted request scanning upward from scan_base_c, wrapping at NREQ.
  always_comb begin
    any_req_c = 1'b0;
    win_c     = '0;
    win_din_c = '0;
    win_amt_c = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_pos = 32'(scan_base_c) + k;
      if (scan_pos >= NREQ) scan_pos = scan_pos - NREQ;
      scan_idx = IDW'(scan_pos);
      if (!any_req_c && req[scan_idx]) begin
        any_req_c = 1'b1;
        win_c     = scan_idx;
        win_din_c = din_a[scan_idx];
        win_amt_c = amt_a[scan_idx];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    win_id_d     = win_id_q;
    csl_din_d    = csl_din_q;
    csl_amount_d = csl_amount_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_dout_d   = rsp_dout_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          csl_din_d    = win_din_c;
          csl_amount_d = {12'b0, win_amt_c};
          gnt_d        = NREQ'(1) << win_c;
          win_id_d     = win_c;
          state_d      = S_CALC;
        end
      end
      S_CALC: begin
        rsp_dout_d  = csl_dout;
        rsp_id_d    = win_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (handshake_c) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      win_id_q     <= '0;
      csl_din_q    <= '0;
      csl_amount_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_dout_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      win_id_q     <= win_id_d;
      csl_din_q    <= csl_din_d;
      csl_amount_q <= csl_amount_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_dout_q   <= rsp_dout_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign csl_din    = csl_din_q;
  assign csl_amount = csl_amount_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_dout   = rsp_dout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_csl_arbiter.sv
// Directed bench for csl_arbiter; provides the shared rotate-left unit behaviourally.
module tb_csl_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_din;
  logic [15:0] req_amt;
  logic [3:0]  gnt;
  logic [15:0] csl_din;
  logic [15:0] csl_amount;
  logic [15:0] csl_dout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_dout;
  logic        rsp_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Shared shifter: rotate left by the 4 LSBs of the amount.
  assign csl_dout = (csl_din << csl_amount[3:0]) | (csl_din >> (5'd16 - {1'b0, csl_amount[3:0]}));

  csl_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_din    (req_din),
    .req_amt    (req_amt),
    .gnt        (gnt),
    .csl_din    (csl_din),
    .csl_amount (csl_amount),
    .csl_dout   (csl_dout),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_dout   (rsp_dout),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  typedef struct {
    int          id;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] rr_dout [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [15:0] d, input logic [3:0] a);
    req_din[16*id +: 16] = d;
    req_amt[4*id +: 4]   = a;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_id;

    vecs[0] = '{id: 1, din: 16'h8001, amt: 4'd1,  exp_dout: 16'h0003};
    vecs[1] = '{id: 0, din: 16'hA5A5, amt: 4'd0,  exp_dout: 16'hA5A5};
    vecs[2] = '{id: 3, din: 16'h0001, amt: 4'd15, exp_dout: 16'h8000};
    vecs[3] = '{id: 2, din: 16'h1234, amt: 4'd4,  exp_dout: 16'h2341};
    vecs[4] = '{id: 2, din: 16'h1234, amt: 4'd8,  exp_dout: 16'h3412};
    vecs[5] = '{id: 0, din: 16'h8000, amt: 4'd1,  exp_dout: 16'h0001};
    rr_dout[0] = 16'h0001;
    rr_dout[1] = 16'h0020;
    rr_dout[2] = 16'h0400;
    rr_dout[3] = 16'h8000;

    rst       = 1'b1;
    req       = '0;
    req_din   = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;

    // Reset state and idle after release.
    tick();
    tick();
    chk("rst_gnt",        32'(gnt),        32'h0);
    chk("rst_csl_din",    32'(csl_din),    32'h0);
    chk("rst_csl_amount", 32'(csl_amount), 32'h0);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'h0);
    chk("rst_rsp_id",     32'(rsp_id),     32'h0);
    chk("rst_rsp_dout",   32'(rsp_dout),   32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_outputs", 32'({gnt, rsp_valid, busy, csl_din}), 32'h0);

    // Single-requester operations from the vector table.
    foreach (vecs[i]) begin
      set_op(vecs[i].id, vecs[i].din, vecs[i].amt);
      req       = 4'b0001 << vecs[i].id;
      rsp_ready = 1'b1;
      tick();
      chk("vec_gnt",        32'(gnt),        32'(4'b0001 << vecs[i].id));
      chk("vec_csl_din",    32'(csl_din),    32'(vecs[i].din));
      chk("vec_csl_amount", 32'(csl_amount), 32'({12'b0, vecs[i].amt}));
      chk("vec_busy",       32'(busy),       32'h1);
      req = '0;
      tick();
      chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("vec_rsp_dout",  32'(rsp_dout),  32'(vecs[i].exp_dout));
      chk("vec_rsp_id",    32'(rsp_id),    32'(vecs[i].id));
      chk("vec_gnt_drop",  32'(gnt),       32'h0);
      tick();
      chk("vec_done_valid", 32'(rsp_valid), 32'h0);
      chk("vec_done_busy",  32'(busy),      32'h0);
    end

    // All four requesting continuously: rotation order and 3-cycle spacing.
    reset_dut();
    for (int i = 0; i < 4; i++) set_op(i, 16'h0001 << (4 * i), 4'(i));
    req       = 4'b1111;
    rsp_ready = 1'b1;
    tick();
    for (int n = 0; n < 5; n++) begin
`ifdef CSL_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % 4;
`endif
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << exp_id));
      if (n == 4) req = '0;
      tick();
      chk("rr_rsp_id",   32'(rsp_id),   32'(exp_id));
      chk("rr_rsp_dout", 32'(rsp_dout), 32'(rr_dout[exp_id]));
      tick();
      chk("rr_gap_gnt", 32'({gnt, rsp_valid}), 32'h0);
      if (n < 4) tick();
    end

    // Stalled response: held stable, busy, and a competing request waits.
    set_op(2, 16'h1234, 4'd4);
    req       = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    chk("stall_gnt", 32'(gnt), 32'h4);
    set_op(0, 16'hBEEF, 4'd0);
    req = 4'b0001;
    tick();
    chk("stall_first_dout", 32'(rsp_dout), 32'h2341);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_dout",  32'(rsp_dout),  32'h2341);
      chk("stall_id",    32'(rsp_id),    32'h2);
      chk("stall_busy",  32'(busy),      32'h1);
      chk("stall_nognt", 32'(gnt),       32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release", 32'({rsp_valid, busy}), 32'h0);
    tick();
    chk("stall_next_gnt", 32'(gnt),     32'h1);
    chk("stall_next_din", 32'(csl_din), 32'hBEEF);
    req = '0;
    tick();
    tick();

    // Reset during CALC; round-robin pointer must return to 0.
    reset_dut();
    set_op(2, 16'h00F0, 4'd2);
    set_op(3, 16'h0F00, 4'd3);
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    tick();
    req = 4'b0100;
    tick();
    chk("rcalc_gnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    req = '0;
    tick();
    chk("rcalc_cleared", 32'({gnt, rsp_valid, busy}), 32'h0);
    rst = 1'b0;
    req = 4'b1100;
    tick();
    chk("rcalc_regnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    tick();

    // Reset during RESP with the response stalled.
    req       = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    req = '0;
    tick();
    chk("rresp_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    tick();
    chk("rresp_cleared", 32'({gnt, rsp_valid, busy}), 32'h0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req       = 4'b1100;
    tick();
    chk("rresp_regnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
